// File: rtl/lc4_div_pkg.sv
// Shared types and constants for the LC4 sequential divider.
// Holds the controller state encoding and the divide-by-zero result values.
package lc4_div_pkg;

  localparam int LC4_WIDTH     = 16;
  localparam int LC4_DIV_CNT_W = 5;

  // LC4 defines x/0 as quotient 0, remainder 0.
  localparam logic [LC4_WIDTH-1:0] LC4_DIV0_QUOTIENT  = '0;
  localparam logic [LC4_WIDTH-1:0] LC4_DIV0_REMAINDER = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/lc4_divider_one_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the outcome into the quotient.
module lc4_divider_one_iter #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] remainder,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextDividend,
  output logic [WIDTH-1:0] nextRemainder,
  output logic [WIDTH-1:0] nextQuotient
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // Kept one bit wider so a remainder with its MSB set still compares correctly.
  assign shifted = {remainder, dividend[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = (shifted >= {1'b0, divisor});

  assign nextRemainder = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign nextQuotient  = {quotient[WIDTH-2:0], fits};
  assign nextDividend  = {dividend[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/lc4_divider_seq.sv
// Iterative unsigned divider for the LC4 execute stage: one restoring step per
// clock behind a start/valid handshake, with abort and divide-by-zero handling.
module lc4_divider_seq
  import lc4_div_pkg::*;
#(
  parameter int WIDTH = LC4_WIDTH,
  parameter int CNT_W = LC4_DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  divState_t        state;
  divState_t        stateNext;
  logic [CNT_W-1:0] iterCnt;
  logic [WIDTH-1:0] dividendReg;
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] stepDividend;
  logic [WIDTH-1:0] stepRemainder;
  logic [WIDTH-1:0] stepQuotient;
  logic             accept;
  logic             divByZero;
  logic             lastIter;

  assign accept    = (state != RUN) && i_start && !i_abort;
  assign divByZero = (i_divisor == '0);
  assign lastIter  = (iterCnt == CNT_W'(WIDTH - 1));

  lc4_divider_one_iter #(.WIDTH(WIDTH)) u_step (
    .dividend      (dividendReg),
    .remainder     (remReg),
    .quotient      (quoReg),
    .divisor       (divisorReg),
    .nextDividend  (stepDividend),
    .nextRemainder (stepRemainder),
    .nextQuotient  (stepQuotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          stateNext = divByZero ? DONE : RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        if (i_abort) begin
          stateNext = IDLE;
        end else if (lastIter) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iterCnt     <= '0;
      dividendReg <= '0;
      divisorReg  <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (accept) begin
      iterCnt     <= '0;
      dividendReg <= i_dividend;
      divisorReg  <= i_divisor;
      remReg      <= '0;
      quoReg      <= '0;
      if (divByZero) begin
        o_quotient  <= WIDTH'(LC4_DIV0_QUOTIENT);
        o_remainder <= WIDTH'(LC4_DIV0_REMAINDER);
      end
    end else if (state == RUN && !i_abort) begin
      iterCnt     <= iterCnt + CNT_W'(1);
      dividendReg <= stepDividend;
      remReg      <= stepRemainder;
      quoReg      <= stepQuotient;
      if (lastIter) begin
        o_quotient  <= stepQuotient;
        o_remainder <= stepRemainder;
      end
    end
  end

  // DONE lasts exactly one cycle per completed result, so it doubles as the valid pulse.
  assign o_busy  = (state == RUN);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Self-checking bench for lc4_divider_seq: directed scenarios plus a randomized
// stream compared against plain integer division.
module tb_lc4_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycleCount  = 0;
  logic [15:0] lastQ;
  logic [15:0] lastR;

  lc4_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic void refDiv(input logic [15:0] a, input logic [15:0] d,
                                 output logic [15:0] q, output logic [15:0] r);
    if (d == 16'd0) begin
      q = 16'd0;
      r = 16'd0;
    end else begin
      q = a / d;
      r = a % d;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge (E0), then scramble the don't-care operands.
  task automatic launch(input logic [15:0] a, input logic [15:0] d);
    i_dividend = a;
    i_divisor  = d;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
  endtask

  task automatic waitValid(input int maxEdges, output bit ok);
    int n = 0;
    while (!o_valid && n < maxEdges) begin
      tick();
      n++;
    end
    ok = o_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_dividend = 16'h0; i_divisor = 16'h0;
    repeat (2) tick();
    nCompared++; if (o_busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy got %b want 0", o_busy); end
    nCompared++; if (o_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid got %b want 0", o_valid); end
    nCompared++; if (o_quotient !== 16'h0) begin nMismatched++; $display("FAIL reset_q got %h want 0000", o_quotient); end
    nCompared++; if (o_remainder !== 16'h0) begin nMismatched++; $display("FAIL reset_r got %h want 0000", o_remainder); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    nCompared++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin nMismatched++; $display("FAIL post_reset_idle got busy=%b valid=%b want 0/0", o_busy, o_valid); end
  endtask

  task automatic test_normal();
    launch(16'd100, 16'd7);
    for (int k = 0; k < 16; k++) begin
      nCompared++;
      if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
        nMismatched++; $display("FAIL normal_busy edge E%0d got busy=%b valid=%b want 1/0", k, o_busy, o_valid);
      end
      if (k < 15) tick();
    end
    tick();
    nCompared++; if (o_valid !== 1'b1 || o_busy !== 1'b0) begin nMismatched++; $display("FAIL normal_valid_E16 got valid=%b busy=%b want 1/0", o_valid, o_busy); end
    nCompared++; if (o_quotient !== 16'd14) begin nMismatched++; $display("FAIL normal_q got %0d want 14", o_quotient); end
    nCompared++; if (o_remainder !== 16'd2) begin nMismatched++; $display("FAIL normal_r got %0d want 2", o_remainder); end
    tick();
    nCompared++; if (o_valid !== 1'b0) begin nMismatched++; $display("FAIL normal_valid_drop got %b want 0", o_valid); end
    nCompared++; if (o_quotient !== 16'd14 || o_remainder !== 16'd2) begin nMismatched++; $display("FAIL normal_hold got %0d r%0d want 14 r2", o_quotient, o_remainder); end
    lastQ = 16'd14; lastR = 16'd2;
  endtask

  task automatic test_div_zero();
    launch(16'h1234, 16'h0000);
    nCompared++; if (o_valid !== 1'b1 || o_busy !== 1'b0) begin nMismatched++; $display("FAIL div0_valid got valid=%b busy=%b want 1/0", o_valid, o_busy); end
    nCompared++; if (o_quotient !== 16'h0 || o_remainder !== 16'h0) begin nMismatched++; $display("FAIL div0_result got %h r%h want 0000 r0000", o_quotient, o_remainder); end
    tick();
    nCompared++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin nMismatched++; $display("FAIL div0_after got valid=%b busy=%b want 0/0", o_valid, o_busy); end
    lastQ = 16'h0; lastR = 16'h0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] as [3] = '{16'hFFFF, 16'h0003, 16'hFFFF};
    logic [15:0] ds [3] = '{16'h0001, 16'hFFFF, 16'hFFFF};
    logic [15:0] eq, er;
    int prevValid = 0;
    bit ok;
    launch(as[0], ds[0]);
    for (int i = 0; i < 3; i++) begin
      waitValid(40, ok);
      nCompared++;
      if (!ok) begin nMismatched++; $display("FAIL b2b_timeout op%0d got no valid want valid", i); return; end
      refDiv(as[i], ds[i], eq, er);
      nCompared++; if (o_quotient !== eq || o_remainder !== er) begin nMismatched++; $display("FAIL b2b_result op%0d got %h r%h want %h r%h", i, o_quotient, o_remainder, eq, er); end
      if (i > 0) begin
        nCompared++; if (cycleCount - prevValid !== 17) begin nMismatched++; $display("FAIL b2b_period op%0d got %0d want 17", i, cycleCount - prevValid); end
      end
      prevValid = cycleCount;
      lastQ = eq; lastR = er;
      if (i < 2) begin
        launch(as[i+1], ds[i+1]);
        nCompared++; if (o_busy !== 1'b1) begin nMismatched++; $display("FAIL b2b_direct_run op%0d got busy=%b want 1", i + 1, o_busy); end
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_start_while_busy();
    int nValid = 0;
    launch(16'd1000, 16'd10);
    repeat (4) tick();
    i_dividend = 16'd5; i_divisor = 16'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    nCompared++; if (o_busy !== 1'b1) begin nMismatched++; $display("FAIL busy_start_busy got %b want 1", o_busy); end
    repeat (10) tick();
    nCompared++; if (o_valid !== 1'b0) begin nMismatched++; $display("FAIL busy_start_early_valid got %b want 0", o_valid); end
    tick();
    nCompared++; if (o_valid !== 1'b1) begin nMismatched++; $display("FAIL busy_start_valid_E16 got %b want 1", o_valid); end
    nCompared++; if (o_quotient !== 16'd100 || o_remainder !== 16'd0) begin nMismatched++; $display("FAIL busy_start_result got %0d r%0d want 100 r0", o_quotient, o_remainder); end
    repeat (20) begin tick(); if (o_valid) nValid++; end
    nCompared++; if (nValid !== 0) begin nMismatched++; $display("FAIL busy_start_second_valid got %0d want 0", nValid); end
    lastQ = 16'd100; lastR = 16'd0;
  endtask

  task automatic test_abort();
    int nValid = 0;
    bit ok;
    launch(16'd50, 16'd3);
    waitValid(40, ok);
    nCompared++; if (!ok || o_quotient !== 16'd16 || o_remainder !== 16'd2) begin nMismatched++; $display("FAIL abort_setup got ok=%0d %0d r%0d want 16 r2", ok, o_quotient, o_remainder); end
    tick();
    lastQ = 16'd16; lastR = 16'd2;
    launch(16'd50, 16'd3);
    repeat (7) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    nCompared++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin nMismatched++; $display("FAIL abort_idle got busy=%b valid=%b want 0/0", o_busy, o_valid); end
    repeat (20) begin tick(); if (o_valid) nValid++; end
    nCompared++; if (nValid !== 0) begin nMismatched++; $display("FAIL abort_valid got %0d want 0", nValid); end
    nCompared++; if (o_quotient !== lastQ || o_remainder !== lastR) begin nMismatched++; $display("FAIL abort_hold got %0d r%0d want %0d r%0d", o_quotient, o_remainder, lastQ, lastR); end
    i_dividend = 16'd9; i_divisor = 16'd0; i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    nCompared++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin nMismatched++; $display("FAIL abort_blocks_start got busy=%b valid=%b want 0/0", o_busy, o_valid); end
  endtask

  task automatic test_reset_mid_run();
    int nValid = 0;
    launch(16'd50, 16'd3);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    nCompared++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin nMismatched++; $display("FAIL rst_mid_flags got busy=%b valid=%b want 0/0", o_busy, o_valid); end
    nCompared++; if (o_quotient !== 16'h0 || o_remainder !== 16'h0) begin nMismatched++; $display("FAIL rst_mid_result got %h r%h want 0000 r0000", o_quotient, o_remainder); end
    tick();
    @(negedge clk) rst_n = 1'b1;
    repeat (25) begin tick(); if (o_valid || o_busy) nValid++; end
    nCompared++; if (nValid !== 0) begin nMismatched++; $display("FAIL rst_mid_after got %0d active cycles want 0", nValid); end
  endtask

  task automatic test_random();
    localparam int N = 2000;
    logic [15:0] a, d, eq, er;
    int errs = 0;
    bit ok;
    void'($urandom(42));
    a = 16'($urandom); d = 16'($urandom);
    launch(a, d);
    for (int i = 0; i < N; i++) begin
      waitValid(40, ok);
      nCompared++;
      if (!ok) begin nMismatched++; errs++; $display("FAIL rand_timeout op%0d got no valid want valid", i); break; end
      refDiv(a, d, eq, er);
      nCompared++;
      if (o_quotient !== eq || o_remainder !== er) begin
        nMismatched++; errs++;
        $display("FAIL rand_result op%0d %h/%h got %h r%h want %h r%h", i, a, d, o_quotient, o_remainder, eq, er);
      end
      if (i < N - 1) begin
        case ($urandom_range(0, 7))
          0: begin a = 16'($urandom); d = 16'h0; end
          1: begin a = 16'($urandom); d = 16'($urandom_range(1, 15)); end
          2: begin a = 16'hFFFF - 16'($urandom_range(0, 3)); d = 16'($urandom); end
          3: begin a = 16'($urandom); d = 16'h8000 | 16'($urandom); end
          default: begin a = 16'($urandom); d = 16'($urandom); end
        endcase
        launch(a, d);
      end else begin
        tick();
      end
    end
    $display("random stream: %0d operations, %0d errors", N, errs);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div_zero();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
